// File: rtl/bresenham_line_engine.sv
// rtl/bresenham_line_engine.sv - all-octant Bresenham line rasteriser with valid/ready pixel stream
module bresenham_line_engine #(
    parameter int COORD_W = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] y0,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] y1,
    output logic               busy,
    output logic               done,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic               pix_last
);

    // Deltas and error term carry two extra bits so |x1-x0| fits with a sign;
    // the doubled error needs one more bit again.
    localparam int DW = COORD_W + 2;
    localparam int EW = COORD_W + 3;

    localparam logic [COORD_W-1:0] C_ONE = COORD_W'(1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_DRAW  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]          state_q,     state_d;
    logic [COORD_W-1:0]  x0_q,        x0_d;
    logic [COORD_W-1:0]  y0_q,        y0_d;
    logic [COORD_W-1:0]  x1_q,        x1_d;
    logic [COORD_W-1:0]  y1_q,        y1_d;
    logic signed [DW-1:0] dx_q,       dx_d;
    logic signed [DW-1:0] dy_q,       dy_d;
    logic signed [DW-1:0] err_q,      err_d;
    logic                sx_neg_q,    sx_neg_d;
    logic                sy_neg_q,    sy_neg_d;
    logic [COORD_W-1:0]  cur_x_q,     cur_x_d;
    logic [COORD_W-1:0]  cur_y_q,     cur_y_d;
    logic                busy_q,      busy_d;
    logic                done_q,      done_d;
    logic                pix_valid_q, pix_valid_d;
    logic                pix_last_q,  pix_last_d;

    // Setup-time geometry derived from the latched endpoints
    logic                 x_fwd;
    logic                 y_fwd;
    logic [COORD_W-1:0]   abs_dx;
    logic [COORD_W-1:0]   abs_dy;
    logic signed [DW-1:0] dx_set;
    logic signed [DW-1:0] dy_set;

    // Per-step Bresenham decision
    logic signed [EW-1:0] e2;
    logic signed [EW-1:0] dx_ext;
    logic signed [EW-1:0] dy_ext;
    logic                 step_x;
    logic                 step_y;
    logic signed [DW-1:0] add_x;
    logic signed [DW-1:0] add_y;
    logic signed [DW-1:0] err_step;
    logic [COORD_W-1:0]   nxt_x;
    logic [COORD_W-1:0]   nxt_y;

    // Absolute deltas and step directions; equal coordinates count as negative direction
    always_comb begin
        x_fwd  = (x0_q < x1_q);
        y_fwd  = (y0_q < y1_q);
        abs_dx = x_fwd ? (x1_q - x0_q) : (x0_q - x1_q);
        abs_dy = y_fwd ? (y1_q - y0_q) : (y0_q - y1_q);
        dx_set = {2'b00, abs_dx};
        dy_set = {DW{1'b0}} - {2'b00, abs_dy};
    end

    // Next pixel and error term for one accepted step (diagonal when both axes move)
    always_comb begin
        e2       = {err_q, 1'b0};
        dx_ext   = {dx_q[DW-1], dx_q};
        dy_ext   = {dy_q[DW-1], dy_q};
        step_x   = (e2 >= dy_ext);
        step_y   = (e2 <= dx_ext);
        add_x    = step_x ? dy_q : {DW{1'b0}};
        add_y    = step_y ? dx_q : {DW{1'b0}};
        err_step = err_q + add_x + add_y;
        nxt_x    = cur_x_q;
        nxt_y    = cur_y_q;
        if (step_x) begin
            nxt_x = sx_neg_q ? (cur_x_q - C_ONE) : (cur_x_q + C_ONE);
        end
        if (step_y) begin
            nxt_y = sy_neg_q ? (cur_y_q - C_ONE) : (cur_y_q + C_ONE);
        end
    end

    // Control FSM: everything holds unless a state transition or handshake updates it
    always_comb begin
        state_d     = state_q;
        x0_d        = x0_q;
        y0_d        = y0_q;
        x1_d        = x1_q;
        y1_d        = y1_q;
        dx_d        = dx_q;
        dy_d        = dy_q;
        err_d       = err_q;
        sx_neg_d    = sx_neg_q;
        sy_neg_d    = sy_neg_q;
        cur_x_d     = cur_x_q;
        cur_y_d     = cur_y_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        pix_valid_d = pix_valid_q;
        pix_last_d  = pix_last_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    x0_d    = x0;
                    y0_d    = y0;
                    x1_d    = x1;
                    y1_d    = y1;
                    busy_d  = 1'b1;
                    state_d = ST_SETUP;
                end
            end

            ST_SETUP: begin
                if (abort) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    dx_d        = dx_set;
                    dy_d        = dy_set;
                    err_d       = dx_set + dy_set;
                    sx_neg_d    = ~x_fwd;
                    sy_neg_d    = ~y_fwd;
                    cur_x_d     = x0_q;
                    cur_y_d     = y0_q;
                    pix_valid_d = 1'b1;
                    pix_last_d  = (x0_q == x1_q) && (y0_q == y1_q);
                    state_d     = ST_DRAW;
                end
            end

            ST_DRAW: begin
                if (abort) begin
                    // Abort wins over a simultaneous handshake; the pixel is dropped
                    busy_d      = 1'b0;
                    pix_valid_d = 1'b0;
                    pix_last_d  = 1'b0;
                    state_d     = ST_IDLE;
                end else if (pix_ready) begin
                    if (pix_last_q) begin
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                        pix_valid_d = 1'b0;
                        pix_last_d  = 1'b0;
                        state_d     = ST_DONE;
                    end else begin
                        err_d      = err_step;
                        cur_x_d    = nxt_x;
                        cur_y_d    = nxt_y;
                        pix_last_d = (nxt_x == x1_q) && (nxt_y == y1_q);
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                busy_d      = 1'b0;
                pix_valid_d = 1'b0;
                pix_last_d  = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            x0_q        <= '0;
            y0_q        <= '0;
            x1_q        <= '0;
            y1_q        <= '0;
            dx_q        <= '0;
            dy_q        <= '0;
            err_q       <= '0;
            sx_neg_q    <= 1'b0;
            sy_neg_q    <= 1'b0;
            cur_x_q     <= '0;
            cur_y_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pix_valid_q <= 1'b0;
            pix_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            x0_q        <= x0_d;
            y0_q        <= y0_d;
            x1_q        <= x1_d;
            y1_q        <= y1_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            err_q       <= err_d;
            sx_neg_q    <= sx_neg_d;
            sy_neg_q    <= sy_neg_d;
            cur_x_q     <= cur_x_d;
            cur_y_q     <= cur_y_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pix_valid_q <= pix_valid_d;
            pix_last_q  <= pix_last_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign pix_valid = pix_valid_q;
    assign pix_last  = pix_last_q;
    assign pix_x     = cur_x_q;
    assign pix_y     = cur_y_q;

endmodule

// File: doc/bresenham_line_engine.md
# bresenham_line_engine

Parametrised, all-octant Bresenham line rasteriser for the VGA graphics path. It accepts a pair of endpoints on a start strobe and emits every pixel of the line, endpoint to endpoint, over a valid/ready stream. The stream feeds the framebuffer write port. Unlike the fixed first-octant generator, it:
- takes runtime endpoints;
- supports any slope and direction;
- supports back-pressure and abort;
- reports busy and done.

## Interface
Parameters:
- COORD_W, 10, unsigned coordinate width (10 covers 640x480).

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request a new line; sampled only in IDLE.
- abort  in  1  terminate current line; sampled in SETUP and DRAW.
- x0, y0  in  COORD_W  start endpoint; latched when start is accepted.
- x1, y1  in  COORD_W  end endpoint; latched when start is accepted.
- busy  out  1  high in SETUP and DRAW.
- done  out  1  one-cycle pulse after the last pixel is accepted.
- pix_valid  out  1  pix_x/pix_y hold a pixel of the line.
- pix_ready  in  1  consumer accepts the pixel when pix_valid && pix_ready.
- pix_x, pix_y  out  COORD_W  current pixel.
- pix_last  out  1  high with pix_valid on the final pixel (x1,y1).

## Operation
- States: IDLE, SETUP, DRAW, DONE.
- IDLE:
  - start=1 latches x0,y0,x1,y1 and moves to SETUP.
  - start=0 stays in IDLE.
- SETUP (1 cycle):
  - dx = |x1-x0| and dy = -|y1-y0|, both signed COORD_W+2 bits.
  - sx = +1 if x0<x1, else -1; sy = +1 if y0<y1, else -1.
  - err = dx + dy.
  - cur = (x0,y0).
  - Next state is DRAW, or IDLE if abort=1.
- DRAW:
  - pix_valid=1, pix_x/pix_y = cur, pix_last = (cur == (x1,y1)).
  - On handshake with pix_last=1: go to DONE.
  - On handshake with pix_last=0, with e2 = 2*err computed at COORD_W+3 bits:
    - if e2 >= dy: err += dy, x += sx;
    - if e2 <= dx: err += dx, y += sy;
    - both updates may apply in the same cycle (diagonal step); new err is the sum of both adjustments.
  - No handshake: cur, err and outputs hold steady.
  - abort=1: go to IDLE and drop the pixel (no done), regardless of pix_ready.
- DONE: done=1 for one cycle, then IDLE.
- Pixel count is max(|x1-x0|, |y1-y0|) + 1.
- Every pixel is 8-connected to its predecessor; the sequence is monotonic in x and in y.
- Degenerate line (x0,y0)==(x1,y1): exactly one pixel, with pix_last=1.
- Horizontal, vertical and 45-degree lines are exact (no error-term drift).
- Coordinates never leave the closed bounding box of the endpoints; no wrap-around is possible at full scale (0 to 2^COORD_W-1).
- start while busy or in DONE is ignored; it is not queued.
- x0..y1 changing after acceptance has no effect on the current line.

## Timing
- Reset values: state=IDLE, busy=0, done=0, pix_valid=0, pix_last=0, pix_x=0, pix_y=0; internal registers zero.
- Reset asserted mid-line: outputs go to reset values immediately (asynchronous). No done pulse. The first start after reset release starts a fresh line.
- start accepted at edge N → busy=1 after edge N. First pix_valid after edge N+1 (2-cycle latency).
- With pix_ready held high: one pixel per clock. An L-pixel line occupies DRAW for L cycles. done is high the cycle after the last handshake; busy falls on that same edge.
- Back-to-back lines: a start held high during the done cycle is accepted on the next cycle, in IDLE. The minimum gap between lines is 2 cycles (DONE, IDLE).
- pix_valid, once high, stays high with stable pix_x/pix_y/pix_last until the handshake or abort.
- abort has priority over a simultaneous handshake. busy falls the next edge.
- All outputs are registered; there is no combinational path from pix_ready to pix_valid.

## Test plan
- (0,0)→(7,3), ready=1 → pixels (0,0)(1,0)(2,1)(3,1)(4,2)(5,2)(6,3)(7,3), last on (7,3). done 1 cycle after; first pixel 2 cycles after start.
- (7,3)→(0,0) and (3,7)→(0,0) → same point sets as the mirrored forward lines, in reverse order; 8 and 8 pixels; all octants sweep with the ref model matching.
- Point (5,5)→(5,5) → single pixel (5,5), pix_last=1, then done. Also vertical (9,0)→(9,4): 5 pixels, x constant at 9.
- ready toggled pseudo-randomly on (0,0)→(639,479) → 640 pixels. Outputs stable while valid && !ready. No pixel duplicated or lost.
- abort asserted on the 3rd DRAW cycle with ready=1 → no further pixels, no done, busy=0 next cycle. A subsequent start draws its new line correctly.
- rst pulsed mid-line → all outputs 0 asynchronously. start ignored while busy: a second start during a line leaves the pixel sequence unchanged.
